fifo_mux_drain_ctrl: RTL and testbench

Read-side controller for the 16-lane output FIFO bank. It owns a 16:1 lane mux plus a one-entry output register and drains a programmed number of words from the 16 lane FIFOs. Lanes are serviced either round-robin or in strict lane order. It generates the mux select, per-lane pop strobes and a valid/ready stream toward the downstream consumer (SFU / memory write path).

---
 rtl/fifo_mux_drain_ctrl.sv | 110 +++++++++++
 tb/tb_fifo_mux_drain_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mux_drain_ctrl.sv
// Read-side drain controller for the 16-lane output FIFO bank: picks a lane
// (round-robin or strict order), pops it, and holds the word in a one-entry output register.
module fifo_mux_drain_ctrl #(
    parameter int unsigned BW   = 4,
    parameter int unsigned SIMD = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic [7:0]             len,
    input  logic [15:0]            lane_empty,
    input  logic [16*SIMD*BW-1:0]  lane_data,
    output logic [15:0]            lane_rd,
    output logic [3:0]             sel,
    output logic [SIMD*BW-1:0]     out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned W = SIMD * BW;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t      state;
    logic [3:0]  ptr;
    logic [3:0]  grant;
    logic [8:0]  issued;
    logic [7:0]  len_q;
    logic        mode_q;
    logic        grant_ok;
    logic        issue;
    logic        accept;

    // Grant search; scanning from the far end lets the lane nearest ptr win.
    always_comb begin
        grant    = ptr;
        grant_ok = 1'b0;
        if (mode_q) begin
            grant_ok = !lane_empty[ptr];
        end else begin
            for (int k = 15; k >= 0; k--) begin
                if (!lane_empty[ptr + 4'(k)]) begin
                    grant    = ptr + 4'(k);
                    grant_ok = 1'b1;
                end
            end
        end
    end

    assign accept  = out_valid && out_ready;
    assign issue   = !reset && (state == RUN) && (issued < {1'b0, len_q})
                     && (!out_valid || out_ready) && grant_ok;
    assign lane_rd = issue ? (16'b1 << grant) : 16'b0;
    assign sel     = issue ? grant : ptr;
    assign busy    = (state != IDLE);
    assign done    = !reset && (state == DRAIN) && accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 4'd0;
            issued    <= 9'd0;
            len_q     <= 8'd0;
            mode_q    <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (len != 8'd0)) begin
                        len_q  <= len;
                        mode_q <= mode;
                        issued <= 9'd0;
                        ptr    <= 4'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (issue && ((issued + 9'd1) == {1'b0, len_q})) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Output register: a new issue overwrites, a bare acceptance empties.
            if (issue) begin
                ptr       <= grant + 4'd1;
                issued    <= issued + 9'd1;
                out       <= lane_data[W*32'(grant) +: W];
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_mux_drain_ctrl.sv
// Randomized scoreboard bench for fifo_mux_drain_ctrl: lane FIFOs are modelled as queues,
// a reference model predicts grants and pushes expected words, a monitor checks acceptances.
module tb_fifo_mux_drain_ctrl;

    localparam int unsigned W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [7:0]       len = 8'd0;
    logic [15:0]      lane_empty = '1;
    logic [16*W-1:0]  lane_data = '0;
    logic [15:0]      lane_rd;
    logic [3:0]       sel;
    logic [W-1:0]     out;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             done;
    logic [15:0]      hold_mask = '0;

    logic [W-1:0] lq [16][$];
    logic [W-1:0] expq [$];

    int  errors = 0;
    int  checks = 0;
    int  rdy_mode = 0;
    int  hold_mode = 0;
    bit  armed = 1'b0;

    always #5 clk = ~clk;

    fifo_mux_drain_ctrl #(.BW(4), .SIMD(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .len        (len),
        .lane_empty (lane_empty),
        .lane_data  (lane_data),
        .lane_rd    (lane_rd),
        .sel        (sel),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    function void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Lane FIFO heads presented first-word fall-through; hold_mask fakes extra emptiness.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 16; i++) begin
            lane_empty[i]         = hold_mask[i] || (lq[i].size() == 0);
            lane_data[i*W +: W]   = (lq[i].size() != 0) ? lq[i][0] : '0;
        end
    end

    // Reference model: drain semantics in plain arithmetic, predicts the coming edge.
    int m_ptr = 0, m_issued = 0, m_len = 0, m_wd = 0;
    bit m_active = 1'b0, m_ov = 1'b0, m_mode = 1'b0, prev_reset = 1'b0;

    always @(negedge clk) begin : model
        int          g;
        bit          gok;
        bit          exp_done;
        bit          was_active;
        logic [15:0] exp_rd;
        if (reset) begin
            if (armed) begin
                chk("rd_in_reset", W'(lane_rd), W'(0));
                chk("done_in_reset", W'(done), W'(0));
            end
            armed      = 1'b1;
            m_active   = 1'b0;
            m_ov       = 1'b0;
            m_ptr      = 0;
            m_issued   = 0;
            prev_reset = 1'b1;
            expq.delete();
        end else if (armed) begin
            if (prev_reset) chk("out_after_reset", out, W'(0));
            prev_reset = 1'b0;
            chk("busy", W'(busy), W'(m_active));
            chk("out_valid", W'(out_valid), W'(m_ov));
            gok = 1'b0;
            g   = m_ptr;
            if (m_active && (m_issued < m_len) && (!m_ov || out_ready)) begin
                if (m_mode) begin
                    gok = !lane_empty[m_ptr];
                end else begin
                    for (int k = 0; k < 16 && !gok; k++) begin
                        if (!lane_empty[(m_ptr + k) % 16]) begin
                            gok = 1'b1;
                            g   = (m_ptr + k) % 16;
                        end
                    end
                end
            end
            exp_rd = '0;
            if (gok) exp_rd[g] = 1'b1;
            chk("lane_rd", W'(lane_rd), W'(exp_rd));
            chk("sel", W'(sel), W'(gok ? g : m_ptr));
            exp_done = m_active && (m_issued == m_len) && m_ov && out_ready;
            chk("done", W'(done), W'(exp_done));
            was_active = m_active;
            if (gok) begin
                expq.push_back(lq[g][0]);
                void'(lq[g].pop_front());
                m_ptr = (g + 1) % 16;
                m_issued++;
                m_ov = 1'b1;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (exp_done) m_active = 1'b0;
            if (!was_active && start && (len != 8'd0)) begin
                m_active = 1'b1;
                m_len    = int'(len);
                m_mode   = mode;
                m_issued = 0;
                m_ptr    = 0;
                m_wd     = 0;
            end
            if (m_active) begin
                m_wd++;
                if (m_wd == 1500) begin
                    checks++;
                    errors++;
                    $display("FAIL watchdog: drain active after %0d cycles, issued %0d of %0d", m_wd, m_issued, m_len);
                end
            end
        end
    end

    // Scoreboard monitor: every accepted word must be the oldest expected one.
    always @(negedge clk) begin : monitor
        if (armed && !reset && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_out: accepted %h, expected no word pending", out);
            end else begin
                chk("sb_out", out, expq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < 16; i++) lq[i].delete();
    endtask

    task automatic fill(input logic [15:0] mask, input int n);
        for (int i = 0; i < 16; i++)
            if (mask[i]) repeat (n) lq[i].push_back($urandom);
    endtask

    task automatic drive_cycle(input int c);
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        case (hold_mode)
            0:       hold_mask = '0;
            1:       hold_mask = (c < 6) ? 16'h0004 : 16'h0000;
            default: hold_mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
        endcase
    endtask

    task automatic run(input bit md, input int ln);
        mode  = md;
        len   = 8'(ln);
        start = 1'b1;
        drive_cycle(0);
        tick();
        start = 1'b0;
        for (int c = 1; c < 2000 && busy; c++) begin
            drive_cycle(c);
            // stray starts while busy must be ignored
            start = (rdy_mode == 2) && ($urandom_range(0, 7) == 0);
            mode  = 1'($urandom);
            len   = 8'($urandom);
            tick();
        end
        start     = 1'b0;
        hold_mask = '0;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // round-robin, all lanes full, len=20
        rdy_mode = 0; hold_mode = 0;
        fill(16'hFFFF, 2);
        run(1'b0, 20);

        // round-robin skipping empty lanes
        clear_lanes();
        fill(16'h8208, 2);
        run(1'b0, 6);

        // sequential mode, lane 2 temporarily empty
        clear_lanes();
        fill(16'hFFFF, 2);
        hold_mode = 1;
        run(1'b1, 4);
        hold_mode = 0;

        // backpressure pattern 1,0,0,1
        clear_lanes();
        fill(16'hFFFF, 2);
        rdy_mode = 1;
        run(1'b0, 12);
        rdy_mode = 0;

        // pointer left at 14, then restarted from 0
        clear_lanes();
        fill(16'hFFFF, 2);
        run(1'b0, 14);
        run(1'b0, 5);

        // len=0 is a no-op
        run(1'b0, 0);

        // len=255 with random backpressure
        clear_lanes();
        fill(16'hFFFF, 17);
        rdy_mode = 2;
        run(1'b0, 255);
        rdy_mode = 0;

        // reset after 7 of 16 words, then a normal len=3 drain
        clear_lanes();
        fill(16'hFFFF, 2);
        mode = 1'b0; len = 8'd16; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        run(1'b0, 3);

        // randomized drains
        rdy_mode = 2; hold_mode = 2;
        for (int r = 0; r < 12; r++) begin
            int ln;
            ln = $urandom_range(1, 40);
            clear_lanes();
            fill(16'hFFFF, ln / 16 + 3);
            run(1'($urandom), ln);
        end
        rdy_mode = 0; hold_mode = 0;

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
